if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch32 pipeline CPU that replaces the multi-cycle core.
- Generates the next PC and drives the synchronous instruction SRAM (1-cycle read latency).
- Holds the fetched instruction when decode stalls, and presents {pc, inst} to the ID stage over a valid/allowin handshake.
- Takes branch/jump redirects from ID and cancels the wrong-path fetch.

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage of the 5-stage LoongArch32 pipeline.
//                Computes nextpc, drives the synchronous instruction SRAM
//                (1-cycle read latency), buffers the fetched word while ID
//                stalls, and hands {pc, inst} to ID over valid/allowin.
//                Branch/jump redirects from ID cancel the wrong-path fetch.
//  Options     : define IF_PERF_CNT_EN to build the fetch/cancel counters;
//                otherwise both counter ports are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_cancel_cnt
);

    // fs_pc resets one step behind RESET_PC so that nextpc = fs_pc + 4
    // naturally produces the first fetch address after release.
    localparam logic [31:0] C_PC_STEP  = 32'd4;
    localparam logic [31:0] C_PC_RESET = RESET_PC - C_PC_STEP;

    logic        r_rst_done;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_inst;

    logic        w_to_fs_valid;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;
    logic [31:0] w_nextpc;
    logic        w_fetch_req;
    logic        w_xfer;
    logic        w_capture;

    // Pipeline control: next PC, allow-in, SRAM request and handshake.
    // Request and valid are additionally gated by resetn so nothing leaks
    // out during the reset cycle itself.
    always_comb begin
        w_to_fs_valid = r_rst_done;
        w_fs_ready_go = 1'b1;
        w_nextpc      = br_taken ? br_target : (r_fs_pc + C_PC_STEP);
        w_fs_allowin  = !r_fs_valid || (ds_allowin && w_fs_ready_go) || br_taken;
        w_fetch_req   = resetn && w_to_fs_valid && w_fs_allowin;
        w_xfer        = resetn && r_fs_valid && w_fs_ready_go && !br_taken && ds_allowin;
        // The SRAM output is only trustworthy the cycle after a read, so a
        // stalled instruction is parked in the buffer on its first stall edge.
        w_capture     = r_fs_valid && !r_buf_valid && !ds_allowin && !br_taken;
    end

    assign fs_to_ds_valid  = resetn && r_fs_valid && w_fs_ready_go && !br_taken;
    assign fs_pc           = r_fs_pc;
    assign fs_inst         = r_buf_valid ? r_buf_inst : inst_sram_rdata;
    assign inst_sram_en    = w_fetch_req;
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'h0;

    // Release tracking: fetching starts the cycle after the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // IF valid/PC register plus stall buffer for the instruction word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fs_valid  <= 1'b0;
            r_fs_pc     <= C_PC_RESET;
            r_buf_valid <= 1'b0;
            r_buf_inst  <= 32'h0;
        end else if (w_fetch_req) begin
            r_fs_valid  <= 1'b1;
            r_fs_pc     <= w_nextpc;
            r_buf_valid <= 1'b0;
        end else if (w_fs_allowin) begin
            // Slot drains with no new fetch behind it.
            r_fs_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (w_capture) begin
            r_buf_inst  <= inst_sram_rdata;
            r_buf_valid <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_cancel_cnt;

    // Count instructions handed to ID and wrong-path fetches discarded.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_fetch_cnt  <= 32'h0;
            r_perf_cancel_cnt <= 32'h0;
        end else begin
            if (w_xfer) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (br_taken && r_fs_valid) begin
                r_perf_cancel_cnt <= r_perf_cancel_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch_cnt;
    assign perf_cancel_cnt = r_perf_cancel_cnt;
`else
    logic w_unused_xfer;
    assign w_unused_xfer   = w_xfer;
    assign perf_fetch_cnt  = 32'h0;
    assign perf_cancel_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. Instruction memory model
//                returns mem[a] = ~a one cycle after an enabled read and
//                random garbage otherwise. Transfers to ID are checked
//                against a queue of expected PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_cancel_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        rstn;
        logic        dsa;
        logic        br;
        logic [31:0] tgt;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[24];

    if_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_cancel_cnt(perf_cancel_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM: data valid only the cycle after an enabled read.
    always @(posedge clk) begin
        if (inst_sram_en === 1'b1) inst_sram_rdata <= ~inst_sram_addr;
        else                       inst_sram_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every ID transfer is compared with the oldest expected PC.
    always @(negedge clk) begin
        if (resetn === 1'b1 && fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL xfer_unexpected: got pc %h expected no transfer (t=%0t)", fs_pc, $time);
            end else begin
                logic [31:0] epc;
                epc = sb_q.pop_front();
                check("xfer_pc", fs_pc, epc);
                check("xfer_inst", fs_inst, ~epc);
            end
        end
    end

    function automatic vec_t mk(input logic rstn, input logic dsa, input logic br,
                                input logic [31:0] tgt, input logic v, input logic [31:0] pc,
                                input logic en, input logic [31:0] addr);
        vec_t r;
        r.rstn = rstn; r.dsa = dsa; r.br = br; r.tgt = tgt;
        r.exp_v = v; r.exp_pc = pc; r.exp_en = en; r.exp_addr = addr;
        return r;
    endfunction

    initial begin
        inst_sram_rdata = 32'h0;
        resetn     = 1'b0;
        ds_allowin = 1'b1;
        br_taken   = 1'b0;
        br_target  = 32'h0;

        //              rstn dsa br  target        v  fs_pc         en addr
        vecs[0]  = mk(0, 1, 0, 32'h0,         0, 32'h1bfffffc, 0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0,         0, 32'h1bfffffc, 0, 32'h0);
        vecs[2]  = mk(1, 1, 0, 32'h0,         0, 32'h1bfffffc, 1, 32'h1c000000);
        vecs[3]  = mk(1, 1, 0, 32'h0,         1, 32'h1c000000, 1, 32'h1c000004);
        vecs[4]  = mk(1, 1, 0, 32'h0,         1, 32'h1c000004, 1, 32'h1c000008);
        vecs[5]  = mk(1, 0, 0, 32'h0,         1, 32'h1c000008, 0, 32'h0);
        vecs[6]  = mk(1, 0, 0, 32'h0,         1, 32'h1c000008, 0, 32'h0);
        vecs[7]  = mk(1, 0, 0, 32'h0,         1, 32'h1c000008, 0, 32'h0);
        vecs[8]  = mk(1, 0, 0, 32'h0,         1, 32'h1c000008, 0, 32'h0);
        vecs[9]  = mk(1, 0, 0, 32'h0,         1, 32'h1c000008, 0, 32'h0);
        vecs[10] = mk(1, 1, 0, 32'h0,         1, 32'h1c000008, 1, 32'h1c00000c);
        vecs[11] = mk(1, 1, 0, 32'h0,         1, 32'h1c00000c, 1, 32'h1c000010);
        vecs[12] = mk(1, 1, 1, 32'h1c000100,  0, 32'h1c000010, 1, 32'h1c000100);
        vecs[13] = mk(1, 1, 0, 32'h0,         1, 32'h1c000100, 1, 32'h1c000104);
        vecs[14] = mk(1, 0, 0, 32'h0,         1, 32'h1c000104, 0, 32'h0);
        vecs[15] = mk(1, 0, 0, 32'h0,         1, 32'h1c000104, 0, 32'h0);
        vecs[16] = mk(1, 0, 1, 32'h1c000200,  0, 32'h1c000104, 1, 32'h1c000200);
        vecs[17] = mk(1, 1, 0, 32'h0,         1, 32'h1c000200, 1, 32'h1c000204);
        vecs[18] = mk(1, 1, 0, 32'h0,         1, 32'h1c000204, 1, 32'h1c000208);
        vecs[19] = mk(0, 1, 0, 32'h0,         0, 32'h1c000208, 0, 32'h0);
        vecs[20] = mk(1, 1, 0, 32'h0,         0, 32'h1bfffffc, 0, 32'h0);
        vecs[21] = mk(1, 1, 0, 32'h0,         0, 32'h1bfffffc, 1, 32'h1c000000);
        vecs[22] = mk(1, 1, 0, 32'h0,         1, 32'h1c000000, 1, 32'h1c000004);
        vecs[23] = mk(1, 1, 0, 32'h0,         1, 32'h1c000004, 1, 32'h1c000008);

        @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            #1;
            resetn     = vecs[i].rstn;
            ds_allowin = vecs[i].dsa;
            br_taken   = vecs[i].br;
            br_target  = vecs[i].tgt;
            if (vecs[i].rstn && vecs[i].exp_v && vecs[i].dsa) sb_q.push_back(vecs[i].exp_pc);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {31'h0, fs_to_ds_valid}, {31'h0, vecs[i].exp_v});
            check($sformatf("v%0d_en", i), {31'h0, inst_sram_en}, {31'h0, vecs[i].exp_en});
            check($sformatf("v%0d_pc", i), fs_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_we_wdata", i), {inst_sram_wdata[31:1], inst_sram_we}, 32'h0);
            if (vecs[i].exp_v) check($sformatf("v%0d_inst", i), fs_inst, ~vecs[i].exp_pc);
            if (vecs[i].exp_en) check($sformatf("v%0d_addr", i), inst_sram_addr, vecs[i].exp_addr);
            @(posedge clk);
        end

        // Eight more back-to-back transfers (ten since the last reset).
        for (int k = 0; k < 8; k++) begin
            #1;
            ds_allowin = 1'b1;
            br_taken   = 1'b0;
            sb_q.push_back(32'h1c000008 + 32'(4 * k));
            @(negedge clk);
            check("stream_pc", fs_pc, 32'h1c000008 + 32'(4 * k));
            @(posedge clk);
        end

        // Two consecutive redirects, each cancelling a valid instruction.
        #1;
        br_taken  = 1'b1;
        br_target = 32'h1c000300;
        @(negedge clk);
        check("redir1_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        check("redir1_addr", inst_sram_addr, 32'h1c000300);
        @(posedge clk);
        #1;
        br_target = 32'h1c000400;
        @(negedge clk);
        check("redir2_pc", fs_pc, 32'h1c000300);
        check("redir2_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        @(posedge clk);
        #1;
        br_taken   = 1'b0;
        ds_allowin = 1'b0;
        @(negedge clk);
        check("redir_final_pc", fs_pc, 32'h1c000400);
        check("redir_final_inst", fs_inst, ~32'h1c000400);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, 32'd10);
        check("perf_cancel", perf_cancel_cnt, 32'd2);
`else
        check("perf_fetch", perf_fetch_cnt, 32'd0);
        check("perf_cancel", perf_cancel_cnt, 32'd0);
`endif
        @(posedge clk);

        // PC wrap-around: redirect to the top of the address space.
        #1;
        ds_allowin = 1'b1;
        br_taken   = 1'b1;
        br_target  = 32'hfffffffc;
        @(negedge clk);
        check("wrap_redir_addr", inst_sram_addr, 32'hfffffffc);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        sb_q.push_back(32'hfffffffc);
        @(negedge clk);
        check("wrap_next_addr", inst_sram_addr, 32'h0);
        @(posedge clk);
        #1;
        ds_allowin = 1'b0;
        @(negedge clk);
        check("wrap_pc", fs_pc, 32'h0);
        check("wrap_inst", fs_inst, 32'hffffffff);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
